// File: rtl/ahb_rd_burst_master_if.sv
// rtl/ahb_rd_burst_master_if.sv - request, AHB-Lite read and response signals of the read burst master
interface ahb_rd_burst_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8
);
  logic                             req_valid;
  logic                             req_pop;
  logic [ADDR_WIDTH-1:0]            req_addr;
  logic [LEN_WIDTH-1:0]             req_len;
  logic [ID_WIDTH-1:0]              req_id;

  logic [ADDR_WIDTH-1:0]            HADDR;
  logic [1:0]                       HTRANS;
  logic                             HWRITE;
  logic [2:0]                       HSIZE;
  logic [2:0]                       HBURST;
  logic                             HREADY;
  logic                             HRESP;
  logic [DATA_WIDTH-1:0]            HRDATA;

  logic                             rsp_push;
  logic [ID_WIDTH+DATA_WIDTH+1:0]   rsp_data;
  logic                             rsp_pop;

  modport master (
    input  req_valid, req_addr, req_len, req_id,
    input  HREADY, HRESP, HRDATA,
    input  rsp_pop,
    output req_pop,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST,
    output rsp_push, rsp_data
  );

  modport slave (
    output req_valid, req_addr, req_len, req_id,
    output HREADY, HRESP, HRDATA,
    output rsp_pop,
    input  req_pop,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST,
    input  rsp_push, rsp_data
  );
endinterface

// File: rtl/ahb_rd_burst_master.sv
// rtl/ahb_rd_burst_master.sv - issues queued read descriptors as AHB-Lite INCR bursts
// Returned beats go to the response FIFO, throttled by a credit counter.
module ahb_rd_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ahb_rd_burst_master_if.master  bus
);
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int CW         = $clog2(RSP_DEPTH + 1);
  localparam int BW         = LEN_WIDTH + 1;

  localparam logic [CW-1:0]         CREDIT_MAX = CW'(RSP_DEPTH);
  localparam logic [2:0]            HSIZE_VAL  = 3'($clog2(BEAT_BYTES));
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BEAT_BYTES);
  localparam logic [BW-1:0]         BEATS_ONE  = BW'(1);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BW-1:0]         r_beats_left;
  logic [ID_WIDTH-1:0]   r_id;
  logic [CW-1:0]         r_credits;
  logic                  r_first;
  logic                  r_cancel;
  logic                  r_pend;
  logic [ID_WIDTH-1:0]   r_pend_id;
  logic                  r_pend_last;

  state_t                w_next_state;
  logic [1:0]            w_htrans;
  logic                  w_accept;
  logic                  w_need_nonseq;
  logic                  w_req_pop;
  logic                  w_push;
  logic                  w_err_start;

  assign w_push      = r_pend && bus.HREADY;
  // First cycle of a two-cycle ERROR response; the following address phase is cancelled.
  assign w_err_start = r_pend && !bus.HREADY && bus.HRESP;

  always_comb begin
    w_next_state  = r_state;
    w_htrans      = TR_IDLE;
    w_req_pop     = 1'b0;
    w_accept      = 1'b0;
    w_need_nonseq = r_first || (r_addr[9:0] == 10'd0);
    if (r_state == ST_IDLE) begin
      w_req_pop = bus.req_valid && !rst;
      if (bus.req_valid) begin
        w_next_state = ST_BURST;
      end
    end else begin
      if (r_cancel) begin
        w_htrans = TR_IDLE;
      end else if (r_credits == '0) begin
        w_htrans = w_need_nonseq ? TR_IDLE : TR_BUSY;
      end else begin
        w_htrans = w_need_nonseq ? TR_NONSEQ : TR_SEQ;
      end
      w_accept = bus.HREADY && w_htrans[1];
      if (w_accept && (r_beats_left == BEATS_ONE)) begin
        w_next_state = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_beats_left <= '0;
      r_id         <= '0;
      r_credits    <= CREDIT_MAX;
      r_first      <= 1'b0;
      r_cancel     <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_id    <= '0;
      r_pend_last  <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && bus.req_valid) begin
        r_addr       <= bus.req_addr;
        r_beats_left <= BW'(bus.req_len) + BEATS_ONE;
        r_id         <= bus.req_id;
        r_first      <= 1'b1;
      end else if (w_accept) begin
        r_addr       <= r_addr + ADDR_STEP;
        r_beats_left <= r_beats_left - BEATS_ONE;
        r_first      <= 1'b0;
      end
      // The held address must restart as NONSEQ once the cancel cycle is over.
      if (w_err_start) begin
        r_first <= 1'b1;
      end
      r_cancel <= w_err_start;

      if (w_accept) begin
        r_pend      <= 1'b1;
        r_pend_id   <= r_id;
        r_pend_last <= (r_beats_left == BEATS_ONE);
      end else if (w_push) begin
        r_pend <= 1'b0;
      end

      case ({w_accept, bus.rsp_pop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   if (r_credits != CREDIT_MAX) r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign bus.req_pop  = w_req_pop;
  assign bus.HADDR    = r_addr;
  assign bus.HTRANS   = w_htrans;
  assign bus.HWRITE   = 1'b0;
  assign bus.HSIZE    = HSIZE_VAL;
  assign bus.HBURST   = 3'b001;
  assign bus.rsp_push = w_push;
  assign bus.rsp_data = w_push ? {r_pend_id, bus.HRESP, r_pend_last, bus.HRDATA} : '0;
endmodule

// File: tb/tb_ahb_rd_burst_master.sv
// tb/tb_ahb_rd_burst_master.sv - scoreboard bench for the AHB read burst master
module tb_ahb_rd_burst_master;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int LW    = 8;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_rd_burst_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

  ahb_rd_burst_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int                  n_chk = 0;
  int                  n_fail = 0;
  logic [IW+DW+1:0]    exp_q[$];
  logic [33:0]         acc_log[$];
  int                  occ;
  int                  push_cnt;
  bit                  auto_pop;
  int                  pop_credit;
  logic [31:0]         wait_addr;
  logic [31:0]         err_addr;
  bit                  wait_en;
  bit                  err_en;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC3A5_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input int len, input logic [3:0] id);
    int n = 0;
    for (int k = 0; k <= len; k++) begin
      logic [31:0] ba;
      ba = a + 32'(4 * k);
      exp_q.push_back({id, err_en && (ba == err_addr), k == len, pat(ba)});
    end
    bus.req_addr  = a;
    bus.req_len   = LW'(len);
    bus.req_id    = id;
    bus.req_valid = 1'b1;
    @(negedge clk);
    while (!bus.req_pop && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_pop", 64'(bus.req_pop), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // AHB slave: optional wait states or a two-cycle ERROR on one chosen address
  initial begin : slave
    bit          pr;
    bit          acc;
    logic [31:0] acc_a;
    bit          dp_v;
    logic [31:0] dp_a;
    int          waits;
    int          err_ph;
    dp_v = 1'b0; dp_a = '0; waits = 0; err_ph = 0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
    forever begin
      @(negedge clk);
      pr    = bus.HREADY;
      acc   = bus.HREADY && bus.HTRANS[1];
      acc_a = bus.HADDR;
      @(posedge clk);
      #1;
      if (rst) begin
        dp_v = 1'b0; waits = 0; err_ph = 0;
      end else if (pr) begin
        dp_v  = acc;
        dp_a  = acc_a;
        waits = (acc && wait_en && acc_a == wait_addr) ? 3 : 0;
        if (acc && err_en && acc_a == err_addr) begin
          err_ph = 1;
          err_en = 1'b0;
        end else begin
          err_ph = 0;
        end
      end else if (waits > 0) begin
        waits--;
      end else if (err_ph == 1) begin
        err_ph = 2;
      end
      if (dp_v && waits > 0) begin
        bus.HREADY = 1'b0; bus.HRESP = 1'b0;
      end else if (err_ph == 1) begin
        bus.HREADY = 1'b0; bus.HRESP = 1'b1;
      end else if (err_ph == 2) begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b1;
      end else begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end
      bus.HRDATA = dp_v ? pat(dp_a) : '0;
    end
  end

  // Response FIFO model plus bus protocol monitor
  initial begin : mon
    logic [1:0]       p_tr;
    logic [31:0]      p_ad;
    bit               p_rdy;
    bit               p_resp;
    logic [IW+DW+1:0] e;
    occ = 0; push_cnt = 0;
    p_tr = '0; p_ad = '0; p_rdy = 1'b1; p_resp = 1'b0;
    bus.rsp_pop = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        occ = 0; p_tr = '0; p_rdy = 1'b1; p_resp = 1'b0;
      end else begin
        if (p_tr[1] && !p_rdy && !p_resp)
          chk("hold", 64'({bus.HTRANS, bus.HADDR}), 64'({p_tr, p_ad}));
        if (!p_rdy && p_resp)
          chk("err_cancel", 64'({bus.HTRANS, bus.HADDR}), 64'({2'b00, p_ad}));
        if (bus.HREADY && bus.HTRANS[1])
          acc_log.push_back({bus.HTRANS, bus.HADDR});
        if (bus.rsp_push) begin
          push_cnt++;
          occ++;
          chk("push_hready", 64'(bus.HREADY), 64'd1);
          chk("rsp_ovf", 64'(occ <= DEPTH), 64'd1);
          chk("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_data", 64'(bus.rsp_data), 64'(e));
          end
        end
        if (bus.rsp_pop) occ--;
        p_tr = bus.HTRANS; p_ad = bus.HADDR; p_rdy = bus.HREADY; p_resp = bus.HRESP;
      end
      @(posedge clk);
      #1;
      if (!rst && occ > 0 && (auto_pop || pop_credit > 0)) begin
        bus.rsp_pop = 1'b1;
        if (!auto_pop) pop_credit--;
      end else begin
        bus.rsp_pop = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [33:0] exp_incr[4];
  logic [33:0] exp_err[3];

  initial begin : main
    exp_incr = '{{2'b10, 32'h3F8}, {2'b11, 32'h3FC}, {2'b10, 32'h400}, {2'b11, 32'h404}};
    exp_err  = '{{2'b10, 32'h600}, {2'b10, 32'h604}, {2'b11, 32'h608}};
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_addr = '0; bus.req_len = '0; bus.req_id = '0;
    auto_pop = 1'b1; pop_credit = 0;
    wait_en = 1'b0; err_en = 1'b0; wait_addr = '0; err_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_htrans", 64'(bus.HTRANS), 64'h0);
    chk("rst_haddr", 64'(bus.HADDR), 64'h0);
    chk("rst_req_pop", 64'(bus.req_pop), 64'h0);
    chk("rst_rsp_push", 64'(bus.rsp_push), 64'h0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'h0);
    chk("hwrite", 64'(bus.HWRITE), 64'h0);
    chk("hsize", 64'(bus.HSIZE), 64'h2);
    chk("hburst", 64'(bus.HBURST), 64'h1);
    bus.req_valid = 1'b0;
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single beat
    issue(32'h100, 0, 4'h3);
    chk("single_trans", 64'(bus.HTRANS), 64'h2);
    chk("single_addr", 64'(bus.HADDR), 64'h100);
    @(posedge clk);
    #1;
    chk("single_push", 64'(bus.rsp_push), 64'h1);
    chk("single_idle", 64'(bus.HTRANS), 64'h0);
    wait_done("single");

    // 4 beats across the 1 KB boundary
    acc_log.delete();
    issue(32'h3F8, 3, 4'h5);
    wait_done("incr4");
    chk("incr4_n", 64'(acc_log.size()), 64'd4);
    for (int i = 0; i < acc_log.size() && i < 4; i++)
      chk("incr4_beat", 64'(acc_log[i]), 64'(exp_incr[i]));

    // credit stall
    auto_pop = 1'b0;
    acc_log.delete();
    issue(32'h2000, 4, 4'h7);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_acc", 64'(acc_log.size()), 64'd2);
    chk("stall_busy", 64'(bus.HTRANS), 64'h1);
    chk("stall_occ", 64'(occ), 64'd2);
    for (int k = 1; k <= 3; k++) begin
      pop_credit = 1;
      repeat (5) @(posedge clk);
      #1;
      chk("stall_release", 64'(acc_log.size()), 64'(2 + k));
      if (k < 3) chk("stall_busy2", 64'(bus.HTRANS), 64'h1);
    end
    auto_pop = 1'b1;
    wait_done("stall");

    // wait states on beat 2 of 3
    wait_addr = 32'h504; wait_en = 1'b1; push_cnt = 0;
    issue(32'h500, 2, 4'h9);
    wait_done("wait");
    chk("wait_pushes", 64'(push_cnt), 64'd3);
    wait_en = 1'b0;

    // ERROR on beat 1 of 3
    acc_log.delete();
    err_addr = 32'h600; err_en = 1'b1;
    issue(32'h600, 2, 4'hA);
    wait_done("err");
    chk("err_n", 64'(acc_log.size()), 64'd3);
    for (int i = 0; i < acc_log.size() && i < 3; i++)
      chk("err_beat", 64'(acc_log[i]), 64'(exp_err[i]));

    // reset mid-burst
    issue(32'h800, 3, 4'hC);
    @(posedge clk);
    #3;
    chk("pre_rst_push", 64'(bus.rsp_push), 64'h1);
    bus.req_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_htrans", 64'(bus.HTRANS), 64'h0);
    chk("mid_rst_haddr", 64'(bus.HADDR), 64'h0);
    chk("mid_rst_rsp_push", 64'(bus.rsp_push), 64'h0);
    chk("mid_rst_rsp_data", 64'(bus.rsp_data), 64'h0);
    chk("mid_rst_req_pop", 64'(bus.req_pop), 64'h0);
    exp_q.delete();
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    auto_pop = 1'b0;
    acc_log.delete();
    issue(32'hC00, 3, 4'hD);
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_credits", 64'(acc_log.size()), 64'(DEPTH));
    if (acc_log.size() > 0)
      chk("post_rst_first", 64'(acc_log[0]), 64'({2'b10, 32'hC00}));
    auto_pop = 1'b1;
    wait_done("post_rst");

    chk("sb_empty_end", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
